// File: rtl/alu_flag_adjust.sv
// Post-ALU stage for the 6502 core: BCD decimal adjust of the ALU result and
// ownership of the processor status register P.
module alu_flag_adjust #(
  parameter logic [7:0] P_RESET = 8'h24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RDY,
  input  logic [7:0] alu_out,
  input  logic       alu_co,
  input  logic       alu_hc,
  input  logic       alu_v,
  input  logic       upd_res,
  input  logic       adj_en,
  input  logic       adj_sub,
  input  logic       ld_nz,
  input  logic       ld_c,
  input  logic       ld_v,
  input  logic       bit_op,
  input  logic       load_p,
  input  logic [7:0] din,
  input  logic [2:0] flag_op,
  input  logic       irq_set,
  input  logic       brk_push,
  output logic [7:0] res_q,
  output logic       res_valid,
  output logic [7:0] p_out,
  output logic       d_flag
);

  typedef enum logic [2:0] {
    FLAG_NONE = 3'd0,
    FLAG_CLC  = 3'd1,
    FLAG_SEC  = 3'd2,
    FLAG_CLI  = 3'd3,
    FLAG_SEI  = 3'd4,
    FLAG_CLD  = 3'd5,
    FLAG_SED  = 3'd6,
    FLAG_CLV  = 3'd7
  } flag_op_e;

  flag_op_e   op;
  logic [3:0] lo_corr, hi_corr;
  logic [3:0] adj_lo, adj_hi;
  logic [7:0] adj_res;
  logic       adj_zero;

  logic [7:0] res_d;
  logic       res_valid_q, res_valid_d;
  logic       n_q, v_q, d_q, i_q, z_q, c_q;
  logic       n_d, v_d, d_d, i_d, z_d, c_d;

  assign op = flag_op_e'(flag_op);

  // Each nibble is corrected on its own; the ALU already propagated the
  // decimal carry between nibbles, so no carry is passed here.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lo_corr = 4'h0;
    hi_corr = 4'h0;
    if (adj_en) begin
      if (adj_sub) begin
        lo_corr = alu_hc ? 4'h0 : 4'hA;
        hi_corr = alu_co ? 4'h0 : 4'hA;
      end else begin
        lo_corr = alu_hc ? 4'h6 : 4'h0;
        hi_corr = alu_co ? 4'h6 : 4'h0;
      end
    end
  end

  assign adj_lo   = alu_out[3:0] + lo_corr;
  assign adj_hi   = alu_out[7:4] + hi_corr;
  assign adj_res  = {adj_hi, adj_lo};
  assign adj_zero = (adj_res == 8'h00);

  always_comb begin
    res_d       = res_q;
    res_valid_d = res_valid_q;
    if (RDY) begin
      res_valid_d = upd_res;
      if (upd_res) res_d = adj_res;
    end
  end

  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (RDY) begin
      if (load_p) begin
        n_d = din[7];
        v_d = din[6];
        d_d = din[3];
        i_d = din[2];
        z_d = din[1];
        c_d = din[0];
      end else begin
        if (ld_nz) begin
          n_d = adj_res[7];
          z_d = adj_zero;
        end
        if (ld_c) c_d = alu_co;
        if (ld_v) v_d = alu_v;
        if (bit_op) begin
          n_d = din[7];
          v_d = din[6];
          z_d = adj_zero;
        end
        // Explicit flag instructions are applied last so they win any clash.
        case (op)
          FLAG_CLC: c_d = 1'b0;
          FLAG_SEC: c_d = 1'b1;
          FLAG_CLI: i_d = 1'b0;
          FLAG_SEI: i_d = 1'b1;
          FLAG_CLD: d_d = 1'b0;
          FLAG_SED: d_d = 1'b1;
          FLAG_CLV: v_d = 1'b0;
          default:  ;
        endcase
      end
      if (irq_set) i_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their next-state values from the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q       <= 8'h00;
      res_valid_q <= 1'b0;
      n_q         <= P_RESET[7];
      v_q         <= P_RESET[6];
      d_q         <= P_RESET[3];
      i_q         <= P_RESET[2];
      z_q         <= P_RESET[1];
      c_q         <= P_RESET[0];
    end else begin
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      n_q         <= n_d;
      v_q         <= v_d;
      d_q         <= d_d;
      i_q         <= i_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  // Bit 5 reads as one and B is supplied by whoever is pushing P.
  assign res_valid = res_valid_q;
  assign p_out     = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign d_flag    = d_q;

endmodule

// File: tb/tb_alu_flag_adjust.sv
// Self-checking bench for alu_flag_adjust: directed scenarios followed by
// randomized traffic compared against a byte-level reference model.
module tb_alu_flag_adjust;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       RDY;
  logic [7:0] alu_out;
  logic       alu_co, alu_hc, alu_v;
  logic       upd_res, adj_en, adj_sub;
  logic       ld_nz, ld_c, ld_v, bit_op, load_p;
  logic [7:0] din;
  logic [2:0] flag_op;
  logic       irq_set, brk_push;
  logic [7:0] res_q;
  logic       res_valid;
  logic [7:0] p_out;
  logic       d_flag;

  int checks   = 0;
  int failures = 0;

  // Reference state: result byte, valid bit and P as a byte (bits 5,4 kept 0).
  logic [7:0] m_res;
  logic       m_valid;
  logic [7:0] m_p;

  always #5 clk = ~clk;

  alu_flag_adjust #(.P_RESET(8'h24)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .RDY      (RDY),
    .alu_out  (alu_out),
    .alu_co   (alu_co),
    .alu_hc   (alu_hc),
    .alu_v    (alu_v),
    .upd_res  (upd_res),
    .adj_en   (adj_en),
    .adj_sub  (adj_sub),
    .ld_nz    (ld_nz),
    .ld_c     (ld_c),
    .ld_v     (ld_v),
    .bit_op   (bit_op),
    .load_p   (load_p),
    .din      (din),
    .flag_op  (flag_op),
    .irq_set  (irq_set),
    .brk_push (brk_push),
    .res_q    (res_q),
    .res_valid(res_valid),
    .p_out    (p_out),
    .d_flag   (d_flag)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_adjust(input logic [7:0] v, input logic hc,
                                            input logic co, input logic en,
                                            input logic sub);
    int lo, hi;
    lo = int'(v) % 16;
    hi = int'(v) / 16;
    if (en) begin
      if (sub) begin
        lo += hc ? 0 : 10;
        hi += co ? 0 : 10;
      end else begin
        lo += hc ? 6 : 0;
        hi += co ? 6 : 0;
      end
    end
    return 8'((hi % 16) * 16 + (lo % 16));
  endfunction

  function automatic logic [7:0] exp_p();
    return m_p | 8'h20 | (brk_push ? 8'h10 : 8'h00);
  endfunction

  task automatic model_reset();
    m_res   = 8'h00;
    m_valid = 1'b0;
    m_p     = 8'h24 & 8'hCF;
  endtask

  // Applies one clock edge's worth of the P / result rules to the model.
  task automatic model_step();
    logic [7:0] adj;
    if (!RDY) return;
    adj = ref_adjust(alu_out, alu_hc, alu_co, adj_en, adj_sub);
    if (upd_res) m_res = adj;
    m_valid = upd_res;
    if (load_p) begin
      m_p = din & 8'hCF;
    end else begin
      if (ld_nz) begin
        m_p[7] = adj[7];
        m_p[1] = (adj == 8'h00);
      end
      if (ld_c) m_p[0] = alu_co;
      if (ld_v) m_p[6] = alu_v;
      if (bit_op) begin
        m_p[7] = din[7];
        m_p[6] = din[6];
        m_p[1] = (adj == 8'h00);
      end
      case (flag_op)
        3'd1: m_p[0] = 1'b0;
        3'd2: m_p[0] = 1'b1;
        3'd3: m_p[2] = 1'b0;
        3'd4: m_p[2] = 1'b1;
        3'd5: m_p[3] = 1'b0;
        3'd6: m_p[3] = 1'b1;
        3'd7: m_p[6] = 1'b0;
        default: ;
      endcase
    end
    if (irq_set) m_p[2] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".res_q"}, res_q, m_res);
    check({tag, ".res_valid"}, {7'b0, res_valid}, {7'b0, m_valid});
    check({tag, ".p_out"}, p_out, exp_p());
    check({tag, ".d_flag"}, {7'b0, d_flag}, {7'b0, m_p[3]});
  endtask

  task automatic set_idle();
    RDY = 1'b1; alu_out = 8'h00; alu_co = 1'b0; alu_hc = 1'b0; alu_v = 1'b0;
    upd_res = 1'b0; adj_en = 1'b0; adj_sub = 1'b0; ld_nz = 1'b0; ld_c = 1'b0;
    ld_v = 1'b0; bit_op = 1'b0; load_p = 1'b0; din = 8'h00; flag_op = 3'd0;
    irq_set = 1'b0; brk_push = 1'b0;
  endtask

  // Inputs are stable from one edge+1 to the next edge; outputs sampled at edge+1.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #12;
    check("rst.p_out", p_out, 8'h24);
    check("rst.res_q", res_q, 8'h00);
    check_all("rst");
    #5 reset_n = 1'b1;
    cycle("idle");
    check("idle.p_out", p_out, 8'h24);

    // Decimal ADC 38+45 (ALU already carried into the high nibble)
    set_idle();
    alu_out = 8'h8D; alu_hc = 1'b1; alu_co = 1'b0; adj_en = 1'b1;
    upd_res = 1'b1; ld_nz = 1'b1; ld_c = 1'b1;
    cycle("adc");
    check("adc.res", res_q, 8'h83);
    check("adc.valid", {7'b0, res_valid}, 8'h01);
    check("adc.nzc", p_out & 8'h83, 8'h80);

    // Decimal SBC 42-15
    set_idle();
    alu_out = 8'h2D; alu_hc = 1'b0; alu_co = 1'b1; adj_en = 1'b1; adj_sub = 1'b1;
    upd_res = 1'b1; ld_nz = 1'b1; ld_c = 1'b1;
    cycle("sbc");
    check("sbc.res", res_q, 8'h27);
    check("sbc.nzc", p_out & 8'h83, 8'h01);

    // Async reset while a capture is pending
    set_idle();
    upd_res = 1'b1; alu_out = 8'h99; flag_op = 3'd6;
    pulse_reset("midrst");
    check("midrst.p_out", p_out, 8'h24);
    check("midrst.res_q", res_q, 8'h00);

    // load_p beats flag_op, irq_set still forces I
    set_idle();
    load_p = 1'b1; din = 8'hC3; flag_op = 3'd2; irq_set = 1'b1; brk_push = 1'b1;
    cycle("prio");
    check("prio.b1", p_out, 8'hF7);
    brk_push = 1'b0;
    #1;
    check("prio.b0", p_out, 8'hE7);

    // BIT: N/V from din, Z from adjusted result, C and D held
    set_idle();
    din = 8'h40; alu_out = 8'h00; bit_op = 1'b1;
    cycle("bit");
    check("bit.p_out", p_out, 8'h67);

    // Stall holds everything, then the capture happens once RDY returns
    set_idle();
    RDY = 1'b0; upd_res = 1'b1; alu_out = 8'h55; flag_op = 3'd6;
    cycle("stall");
    check("stall.res", res_q, 8'h00);
    check("stall.d", {7'b0, d_flag}, 8'h00);
    RDY = 1'b1;
    cycle("unstall");
    check("unstall.res", res_q, 8'h55);
    check("unstall.d", {7'b0, d_flag}, 8'h01);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RDY      = ($urandom_range(0, 9) != 0);
      alu_out  = 8'($urandom);
      alu_co   = 1'($urandom);
      alu_hc   = 1'($urandom);
      alu_v    = 1'($urandom);
      upd_res  = 1'($urandom);
      adj_en   = 1'($urandom);
      adj_sub  = 1'($urandom);
      ld_nz    = 1'($urandom);
      ld_c     = 1'($urandom);
      ld_v     = 1'($urandom);
      bit_op   = ($urandom_range(0, 5) == 0);
      load_p   = ($urandom_range(0, 7) == 0);
      din      = 8'($urandom);
      flag_op  = 3'($urandom);
      irq_set  = ($urandom_range(0, 7) == 0);
      brk_push = 1'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset("rnd_rst");
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
